// File: rtl/sbox_bank_sched_if.sv
// Signal bundle between the S-box bank scheduler, its two requesters
// (round datapath and key expansion) and the shared 32-bit S-box bank.
interface sbox_bank_sched_if;
  // round datapath side
  logic         st_req;
  logic [127:0] st_data;
  logic         st_done;
  logic [127:0] st_result;
  // key expansion side
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_rot;
  logic         key_done;
  logic [31:0]  key_result;
  // S-box bank side
  logic [31:0]  sbox_in;
  logic         sbox_in_vld;
  logic [31:0]  sbox_out;
  // status
  logic         busy;

  modport slave (
    input  st_req, st_data, key_req, key_word, key_rot, sbox_out,
    output st_done, st_result, key_done, key_result, sbox_in, sbox_in_vld, busy
  );

  modport master (
    output st_req, st_data, key_req, key_word, key_rot, sbox_out,
    input  st_done, st_result, key_done, key_result, sbox_in, sbox_in_vld, busy
  );
endinterface

// File: rtl/sbox_bank_sched.sv
// Shares one 32-bit S-box bank between the round datapath (4-word SubBytes)
// and the key expansion (one SubWord, optional RotWord). One operation is in
// flight at a time; a {valid, index} tag pipe matched to the bank latency
// steers each returning word into its result lane.
module sbox_bank_sched #(
  parameter int SBOX_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sbox_bank_sched_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic OWN_ST  = 1'b0;
  localparam logic OWN_KEY = 1'b1;

  // Word idx of the 128-bit state, word 0 in the low bits.
  function automatic logic [31:0] st_word(input logic [127:0] data, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = data[31:0];
      2'd1:    w = data[63:32];
      2'd2:    w = data[95:64];
      2'd3:    w = data[127:96];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Key word as presented to the bank, RotWord applied on request.
  function automatic logic [31:0] key_sel(input logic [31:0] word, input logic rot);
    logic [31:0] w;
    if (rot) begin
      w = {word[23:0], word[31:24]};
    end else begin
      w = word;
    end
    return w;
  endfunction

  state_e       state_q, state_d;
  logic         owner_q, owner_d;          // requester currently being served
  logic         last_grant_q, last_grant_d;
  logic [1:0]   cnt_q, cnt_d;              // index of the word on sbox_in
  logic [31:0]  sbox_in_q, sbox_in_d;
  logic         vld_q, vld_d;
  logic         st_done_q, st_done_d;
  logic         key_done_q, key_done_d;
  logic         busy_q;
  logic [127:0] st_result_q, st_result_d;
  logic [31:0]  key_result_q, key_result_d;
  logic [2:0]   tag_q [SBOX_LAT];          // {valid, word index}
  logic [2:0]   tag_exit_s;
  logic         last_tag_s;
  logic         grant_s;

  assign tag_exit_s = tag_q[SBOX_LAT-1];
  assign last_tag_s = tag_exit_s[2] && ((owner_q == OWN_KEY) || (tag_exit_s[1:0] == 2'd3));

  // Arbitration, word issue sequencing and completion detection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sbox_in_d    = 32'd0;
    vld_d        = 1'b0;
    st_done_d    = 1'b0;
    key_done_d   = 1'b0;
    grant_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.st_req && bus.key_req) begin
          grant_s      = 1'b1;
          owner_d      = ~last_grant_q;
          last_grant_d = ~last_grant_q;
        end else if (bus.st_req) begin
          grant_s = 1'b1;
          owner_d = OWN_ST;
        end else if (bus.key_req) begin
          grant_s = 1'b1;
          owner_d = OWN_KEY;
        end else begin
          grant_s = 1'b0;
        end
        if (grant_s) begin
          state_d = S_ISSUE;
          cnt_d   = 2'd0;
          vld_d   = 1'b1;
          if (owner_d == OWN_KEY) begin
            sbox_in_d = key_sel(bus.key_word, bus.key_rot);
          end else begin
            sbox_in_d = st_word(bus.st_data, 2'd0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ((owner_q == OWN_KEY) || (cnt_q == 2'd3)) begin
          cnt_d   = 2'd0;
          state_d = S_DRAIN;
        end else begin
          cnt_d     = cnt_q + 2'd1;
          vld_d     = 1'b1;
          sbox_in_d = st_word(bus.st_data, cnt_q + 2'd1);
        end
      end
      S_DRAIN: begin
        if (last_tag_s) begin
          state_d    = S_DONE;
          st_done_d  = (owner_q == OWN_ST);
          key_done_d = (owner_q == OWN_KEY);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result capture: the word leaving the tag pipe lands in its lane.
  always_comb begin
    st_result_d  = st_result_q;
    key_result_d = key_result_q;
    if (tag_exit_s[2]) begin
      if (owner_q == OWN_KEY) begin
        key_result_d = bus.sbox_out;
      end else begin
        case (tag_exit_s[1:0])
          2'd0:    st_result_d[31:0]   = bus.sbox_out;
          2'd1:    st_result_d[63:32]  = bus.sbox_out;
          2'd2:    st_result_d[95:64]  = bus.sbox_out;
          2'd3:    st_result_d[127:96] = bus.sbox_out;
          default: st_result_d = st_result_q;
        endcase
      end
    end else begin
      key_result_d = key_result_q;
    end
  end

  // State, issue, tag pipe and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_ST;
      last_grant_q <= OWN_KEY;
      cnt_q        <= 2'd0;
      sbox_in_q    <= 32'd0;
      vld_q        <= 1'b0;
      st_done_q    <= 1'b0;
      key_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      st_result_q  <= 128'd0;
      key_result_q <= 32'd0;
      for (int k = 0; k < SBOX_LAT; k++) begin
        tag_q[k] <= 3'd0;
      end
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      sbox_in_q    <= sbox_in_d;
      vld_q        <= vld_d;
      st_done_q    <= st_done_d;
      key_done_q   <= key_done_d;
      busy_q       <= (state_d != S_IDLE);
      st_result_q  <= st_result_d;
      key_result_q <= key_result_d;
      tag_q[0]     <= {vld_q, cnt_q};
      for (int k = 1; k < SBOX_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign bus.sbox_in     = sbox_in_q;
  assign bus.sbox_in_vld = vld_q;
  assign bus.st_done     = st_done_q;
  assign bus.key_done    = key_done_q;
  assign bus.st_result   = st_result_q;
  assign bus.key_result  = key_result_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_sbox_bank_sched.sv
// Bench for sbox_bank_sched: three instances (SBOX_LAT = 2, 1, 8), each with
// a golden AES S-box bank model. Expected issued words and completions are
// queued when a request is driven and compared when the DUT produces them.
module tb_sbox_bank_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [2:0]   st_req, key_req, key_rot;
  logic [127:0] st_data [3];
  logic [31:0]  key_word [3];
  logic [2:0]   st_done, key_done, busy, sbox_in_vld;
  logic [127:0] st_result [3];
  logic [31:0]  key_result [3];
  logic [31:0]  sbox_in [3];

  typedef struct { logic [31:0] w; int cyc; } iss_t;
  typedef struct { bit is_key; logic [127:0] res; int cyc; } done_t;
  iss_t  iss_q [$];
  done_t done_q [$];
  int          vld_cnt [3];
  logic [31:0] last_iss [3];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // AES S-box: inverse as x^254 in GF(2^8), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base;
    r = 8'h01; base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbox_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sbox128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sbox_word(v[32*i +: 32]);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    sbox_bank_sched_if u_if ();
    logic [31:0] pipe [L];

    assign u_if.st_req   = st_req[g];
    assign u_if.st_data  = st_data[g];
    assign u_if.key_req  = key_req[g];
    assign u_if.key_word = key_word[g];
    assign u_if.key_rot  = key_rot[g];
    assign u_if.sbox_out = pipe[L-1];
    assign st_done[g]     = u_if.st_done;
    assign key_done[g]    = u_if.key_done;
    assign busy[g]        = u_if.busy;
    assign sbox_in_vld[g] = u_if.sbox_in_vld;
    assign sbox_in[g]     = u_if.sbox_in;
    assign st_result[g]   = u_if.st_result;
    assign key_result[g]  = u_if.key_result;

    // Bank model: result of the word presented in cycle c appears in cycle c+L.
    always @(posedge clk) begin
      pipe[0] <= sbox_word(u_if.sbox_in);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    sbox_bank_sched #(.SBOX_LAT(L)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_st(input int d, input logic [127:0] data, input int g);
    iss_t it;
    done_t dn;
    for (int i = 0; i < 4; i++) begin
      it.w = data[32*i +: 32];
      it.cyc = g + 1 + i;
      iss_q.push_back(it);
    end
    dn.is_key = 1'b0; dn.res = sbox128(data); dn.cyc = g + 5 + lat(d);
    done_q.push_back(dn);
  endtask

  task automatic push_key(input int d, input logic [31:0] w, input logic rot, input int g);
    iss_t it;
    done_t dn;
    it.w = rot ? {w[23:0], w[31:24]} : w;
    it.cyc = g + 1;
    iss_q.push_back(it);
    dn.is_key = 1'b1; dn.res = {96'd0, sbox_word(it.w)}; dn.cyc = g + 2 + lat(d);
    done_q.push_back(dn);
  endtask

  // Issue monitor: every valid word must be the next expected one, on time.
  always @(negedge clk) begin : mon_issue
    iss_t e;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (sbox_in_vld[d]) begin
          vld_cnt[d]++;
          last_iss[d] = sbox_in[d];
          if (iss_q.size() == 0) begin
            check("issue_unexpected", 128'(sbox_in[d]), 128'hx);
          end else begin
            e = iss_q.pop_front();
            check("issue_word", 128'(sbox_in[d]), 128'(e.w));
            check("issue_cycle", 128'(cyc), 128'(e.cyc));
          end
        end else if (sbox_in[d] !== 32'd0) begin
          check("sbox_in_idle_zero", 128'(sbox_in[d]), 128'd0);
        end
      end
    end
  end

  // Completion monitor: kind, result and cycle of each done pulse.
  always @(negedge clk) begin : mon_done
    done_t e;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (st_done[d] || key_done[d]) begin
          if (done_q.size() == 0) begin
            check("done_unexpected", 128'({st_done[d], key_done[d]}), 128'd0);
          end else begin
            e = done_q.pop_front();
            check("done_kind", 128'({st_done[d], key_done[d]}), 128'({~e.is_key, e.is_key}));
            check("done_result", e.is_key ? 128'(key_result[d]) : st_result[d], e.res);
            check("done_cycle", 128'(cyc), 128'(e.cyc));
          end
        end
      end
    end
  end

  task automatic wait_done_drop(input int d, input bit is_key);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_key ? key_done[d] : st_done[d]) begin
        seen = 1'b1;
        if (is_key) key_req[d] = 1'b0;
        else st_req[d] = 1'b0;
      end
    end
    check(is_key ? "key_done_wait" : "st_done_wait", 128'(seen), 128'd1);
  endtask

  task automatic run_st(input int d, input logic [127:0] data);
    @(negedge clk);
    st_data[d] = data;
    st_req[d] = 1'b1;
    push_st(d, data, cyc);
    wait_done_drop(d, 1'b0);
  endtask

  task automatic run_key(input int d, input logic [31:0] w, input logic rot);
    @(negedge clk);
    key_word[d] = w;
    key_rot[d] = rot;
    key_req[d] = 1'b1;
    push_key(d, w, rot, cyc);
    wait_done_drop(d, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int gc;
    bit any_done;
    logic [127:0] rnd;
    logic [31:0] kw;
    st_req = 3'd0; key_req = 3'd0; key_rot = 3'd0;
    for (int d = 0; d < 3; d++) begin
      st_data[d] = 128'd0; key_word[d] = 32'd0; vld_cnt[d] = 0; last_iss[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_outputs", 128'({st_done[d], key_done[d], sbox_in_vld[d], busy[d]}), 128'd0);
      check("rst_sbox_in", 128'(sbox_in[d]), 128'd0);
      check("rst_st_result", st_result[d], 128'd0);
      check("rst_key_result", 128'(key_result[d]), 128'd0);
    end
    mon_en = 1'b1;

    // state op on zero state: every byte becomes 63, four issues
    vld_cnt[0] = 0;
    run_st(0, 128'd0);
    check("t1_result", st_result[0], {16{8'h63}});
    check("t1_vld_pulses", 128'(vld_cnt[0]), 128'd4);

    // key op with and without RotWord
    vld_cnt[0] = 0;
    run_key(0, 32'h09CF4F3C, 1'b1);
    check("t2_sbox_in_rot", 128'(last_iss[0]), 128'h0000_0000_0000_0000_0000_0000_CF4F_3C09);
    check("t2_key_result", 128'(key_result[0]), 128'h0000_0000_0000_0000_0000_0000_8A84_EB01);
    check("t2_vld_pulses", 128'(vld_cnt[0]), 128'd1);
    run_key(0, 32'h53535353, 1'b0);
    check("t2_key_norot", 128'(key_result[0]), 128'h0000_0000_0000_0000_0000_0000_EDED_EDED);

    // simultaneous requests after reset: state first, then key
    pulse_reset();
    @(negedge clk);
    gc = cyc;
    st_data[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF; st_req[0] = 1'b1;
    key_word[0] = 32'h2B7E1516; key_rot[0] = 1'b1; key_req[0] = 1'b1;
    push_st(0, st_data[0], gc);
    push_key(0, key_word[0], 1'b1, gc + 8);
    wait_done_drop(0, 1'b0);
    wait_done_drop(0, 1'b1);
    // repeat: round-robin now favours the key requester
    @(negedge clk);
    gc = cyc;
    st_data[0] = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3; st_req[0] = 1'b1;
    key_word[0] = 32'hA0FAFE17; key_rot[0] = 1'b0; key_req[0] = 1'b1;
    push_key(0, key_word[0], 1'b0, gc);
    push_st(0, st_data[0], gc + 5);
    wait_done_drop(0, 1'b1);
    wait_done_drop(0, 1'b0);

    // key request arriving during a state op waits for the following IDLE
    @(negedge clk);
    gc = cyc;
    st_data[0] = 128'h3243F6A8_885A308D_313198A2_E0370734; st_req[0] = 1'b1;
    push_st(0, st_data[0], gc);
    @(negedge clk);
    @(negedge clk);
    key_word[0] = 32'h762E7160; key_rot[0] = 1'b1; key_req[0] = 1'b1;
    push_key(0, key_word[0], 1'b1, gc + 8);
    wait_done_drop(0, 1'b0);
    wait_done_drop(0, 1'b1);

    // reset during DRAIN: no done, no stale capture, next op clean
    @(negedge clk);
    gc = cyc;
    st_data[0] = 128'hFFEEDDCC_BBAA9988_77665544_33221100; st_req[0] = 1'b1;
    push_st(0, st_data[0], gc);
    while (cyc < gc + 5) @(negedge clk);
    check("t5_busy_before", 128'(busy[0]), 128'd1);
    check("t5_issues_done", 128'(iss_q.size()), 128'd0);
    rst_n = 1'b0;
    st_req[0] = 1'b0;
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy_after", 128'(busy[0]), 128'd0);
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_done = any_done | st_done[0] | key_done[0];
    end
    check("t5_no_done", 128'(any_done), 128'd0);
    check("t5_no_stale", st_result[0], 128'd0);
    run_st(0, 128'h01020304_05060708_090A0B0C_0D0E0F10);
    run_key(0, 32'hC0FFEE11, 1'b1);

    // latency sweep on SBOX_LAT = 1 and 8
    for (int d = 1; d < 3; d++) begin
      for (int k = 0; k < 2; k++) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_st(d, rnd);
        kw = $urandom;
        run_key(d, kw, k[0]);
      end
      @(negedge clk);
      gc = cyc;
      st_data[d] = {$urandom, $urandom, $urandom, $urandom}; st_req[d] = 1'b1;
      key_word[d] = $urandom; key_rot[d] = 1'b1; key_req[d] = 1'b1;
      push_st(d, st_data[d], gc);
      push_key(d, key_word[d], 1'b1, gc + 6 + lat(d));
      wait_done_drop(d, 1'b0);
      wait_done_drop(d, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("end_done_queue", 128'(done_q.size()), 128'd0);
    check("end_issue_queue", 128'(iss_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sbox_bank_sched.md
Name: sbox_bank_sched

Overview:
- Scheduler that shares one 32-bit AES S-box bank between two requesters:
  - the round datapath (SubBytes over a 128-bit state);
  - the key expansion (SubWord/RotWord over a 32-bit word).
- The bank is four byte lanes, each an inversion stage followed by affine mapping, with fixed pipeline latency. It sits outside this block.
- This block arbitrates, slices and issues words, realigns the returning results, and reports completion per requester.

Parameters:
- SBOX_LAT, 2, cycles from sbox_in_vld to valid sbox_out; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- st_req  in  1  state SubBytes request; held high until st_done
- st_data  in  128  state input; stable while st_req is high
- st_done  out  1  one-cycle completion pulse
- st_result  out  128  substituted state; valid when st_done=1, held afterwards
- key_req  in  1  key SubWord request; held high until key_done
- key_word  in  32  key word; stable while key_req is high
- key_rot  in  1  apply RotWord before SubWord
- key_done  out  1  one-cycle completion pulse
- key_result  out  32  substituted word; valid when key_done=1, held afterwards
- sbox_in  out  32  word to the S-box bank
- sbox_in_vld  out  1  sbox_in valid this cycle
- sbox_out  in  32  bank result, valid exactly SBOX_LAT cycles after sbox_in_vld
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst_n sampled low at a clk edge forces IDLE, last_grant=KEY, and all counters and the return tag pipe to 0.
  - Outputs after reset: st_done=0, key_done=0, sbox_in_vld=0, sbox_in=0, st_result=0, key_result=0, busy=0.
  - Reset mid-operation discards in-flight words; no done pulse follows.
- FSM states: IDLE, ISSUE, DRAIN, DONE. Only one operation is in flight at a time; no overlap between requesters.
- IDLE, arbitration:
  - only one request high → grant it;
  - both high → grant the requester other than last_grant, then update last_grant.
  - Grant cycle G; next state is ISSUE.
- ISSUE, state op:
  - cycles G+1..G+4 issue words 0..3 with sbox_in_vld=1;
  - word i = st_data[32i+31:32i];
  - a 2-bit issue counter wraps 3→0 and the FSM moves to DRAIN.
- ISSUE, key op:
  - cycle G+1 issues one word;
  - key_rot=1 → sbox_in = {key_word[23:0], key_word[31:24]};
  - key_rot=0 → sbox_in = key_word;
  - then DRAIN.
- Return path:
  - a tag shift register of depth SBOX_LAT carries {valid, word index}.
  - When a tag exits, sbox_out is written to the matching result lane: st_result[32i+31:32i] or key_result.
  - The result register is updated only by captures.
- DRAIN: waits until the last tag has been captured, then DONE.
- DONE: pulses the granted requester's done for exactly 1 cycle, then IDLE.
  - A request still high in that IDLE cycle is treated as a new request; the requester must drop req on done.
- Latency from grant G:
  - state op: captures at G+1+SBOX_LAT .. G+4+SBOX_LAT; st_done at G+5+SBOX_LAT;
  - key op: capture at G+1+SBOX_LAT; key_done at G+2+SBOX_LAT.
- Request dropped after grant: the operation still completes and done still pulses. Inputs are sampled per issue cycle, so the owner must keep data stable.
- A request arriving while busy waits; it is arbitrated at the next IDLE.
- sbox_in is 0 whenever sbox_in_vld=0.
- Words for a state op are never issued while a key tag is in flight, and vice versa.

Test Plan:
1. State op, SBOX_LAT=2, bank modelled with the true AES S-box:
   - st_data=128'h0 → st_result=128'h6363...63;
   - st_done exactly 7 cycles after grant; exactly 4 sbox_in_vld pulses.
2. Key op with rotation:
   - key_word=32'h09CF4F3C, key_rot=1 → sbox_in=32'hCF4F3C09, key_result=32'h8A84EB01;
   - key_done at G+4.
   - key_rot=0 with key_word=32'h53535353 → key_result=32'hEDEDEDED.
3. Simultaneous requests:
   - st_req and key_req rise in the same cycle after reset (last_grant=KEY) → state served first, key next.
   - Repeat → key served first this time (round-robin).
4. Request while busy: key_req rises during a state op's ISSUE → no key word is issued until st_done; key is granted in the following IDLE.
5. Reset mid-operation:
   - rst_n low for 1 cycle during DRAIN → busy=0 and no done pulse;
   - the next request completes with correct results and stale tags are not captured.
6. Latency sweep, SBOX_LAT=1 and 8, random st_data and key words → results match the golden S-box; done timing matches the formulas above.
